// File: rtl/fm_modulator_pl.sv
// Pipelined FM modulator: runtime carrier/deviation config applied on phase wrap,
// audio hold with underrun timeout, piecewise-linear sine out. Optional: FM_PHASE_DITHER_EN.
module fm_modulator_pl #(
  parameter int A        = 8,
  parameter int N        = 18,
  parameter int D        = 5,
  parameter int DF_W     = 12,
  parameter int HOLD_MAX = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [A-1:0]    audio,
  input  logic            audio_valid,
  input  logic            cfg_valid,
  input  logic [N-1:0]    fc_inc,
  input  logic [DF_W-1:0] df_inc,
  output logic            cfg_pending,
  output logic            underrun,
  output logic [D-1:0]    rf
);
  localparam int PW = A + DF_W + 1;
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [D-1:0]  MID      = D'(1 << (D - 1));
  localparam logic [D-2:0]  QTR      = (D-1)'(1 << (D - 3));
  localparam logic [D-2:0]  MAG_MAX  = {(D-1){1'b1}};
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  logic [N-1:0]       phase_reg;
  logic [N-1:0]       fc_act_reg, fc_sh_reg;
  logic [DF_W-1:0]    df_act_reg, df_sh_reg;
  logic signed [A-1:0] held_reg;
  logic [CW-1:0]      hold_cnt_reg;
  logic               cfg_pending_reg, underrun_reg;
  logic [D-2:0]       mag_reg;
  logic               neg_reg;
  logic [D-1:0]       rf_reg;

  assign cfg_pending = cfg_pending_reg;
  assign underrun    = underrun_reg;
  assign rf          = rf_reg;

  // Deviation: held sample scaled by df, floor-shifted back by A-1, then sign-extended/truncated to N bits.
  logic signed [PW-1:0]   held_ext, df_ext, prod, prod_sh;
  logic signed [N+PW-1:0] prod_wide;
  logic [N-1:0]           mod_val;
  assign held_ext  = {{(PW-A){held_reg[A-1]}}, held_reg};
  assign df_ext    = {{(PW-DF_W){1'b0}}, df_act_reg};
  assign prod      = held_ext * df_ext;
  assign prod_sh   = prod >>> (A - 1);
  assign prod_wide = {{N{prod_sh[PW-1]}}, prod_sh};
  assign mod_val   = prod_wide[N-1:0];

  // Three spare bits hold carry (>= 2^N) or borrow (< 0); any set bit means the phase wrapped.
  logic [N+2:0] sum_ext;
  logic         wrap, apply;
  assign sum_ext = {3'b000, phase_reg} + {3'b000, fc_act_reg} + {{3{mod_val[N-1]}}, mod_val};
  assign wrap    = |sum_ext[N+2:N];
  assign apply   = cfg_pending_reg & (wrap | ~en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_reg     <= '0;
      hold_cnt_reg <= '0;
      underrun_reg <= 1'b1;
    end else if (audio_valid) begin
      held_reg     <= audio;
      hold_cnt_reg <= '0;
      underrun_reg <= 1'b0;
    end else if (hold_cnt_reg != CNT_MAX) begin
      hold_cnt_reg <= hold_cnt_reg + CW'(1);
      if (hold_cnt_reg == CNT_LAST) begin
        held_reg     <= '0;
        underrun_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
    end else if (en) begin
      phase_reg <= sum_ext[N-1:0];
    end else begin
      phase_reg <= '0;
    end
  end

  // A write landing on the apply cycle stays in shadow and keeps pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_act_reg      <= '0;
      df_act_reg      <= '0;
      fc_sh_reg       <= '0;
      df_sh_reg       <= '0;
      cfg_pending_reg <= 1'b0;
    end else begin
      if (apply) begin
        fc_act_reg <= fc_sh_reg;
        df_act_reg <= df_sh_reg;
      end
      if (cfg_valid) begin
        fc_sh_reg       <= fc_inc;
        df_sh_reg       <= df_inc;
        cfg_pending_reg <= 1'b1;
      end else if (apply) begin
        cfg_pending_reg <= 1'b0;
      end
    end
  end

  logic [N-1:0] ph2;
`ifdef FM_PHASE_DITHER_EN
  localparam int K = (N - D - 1 < 16) ? (N - D - 1) : 16;
  logic [15:0] lfsr_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end
  assign ph2 = phase_reg + {{(N-K){1'b0}}, lfsr_reg[K-1:0]};
`else
  assign ph2 = phase_reg;
`endif

  // ph_hi = {quadrant, top D-1 bits of the in-quadrant phase}.
  logic [D:0]   ph_hi;
  logic [D-2:0] pt, mag_next;
  logic [D-1:0] rf_next;
  assign ph_hi = ph2[N-1:N-1-D];

  always_comb begin
    pt       = ph_hi[D-1] ? ~ph_hi[D-2:0] : ph_hi[D-2:0];
    mag_next = MAG_MAX;
    case (pt[D-2:D-3])
      2'd0:    mag_next = {pt[D-3:0], 1'b0};
      2'd3:    mag_next = MAG_MAX;
      default: mag_next = QTR + pt;
    endcase
  end

  assign rf_next = neg_reg ? (MID - {1'b0, mag_reg}) : (MID + {1'b0, mag_reg});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_reg <= '0;
      neg_reg <= 1'b0;
      rf_reg  <= MID;
    end else if (!en) begin
      mag_reg <= '0;
      neg_reg <= 1'b0;
      rf_reg  <= MID;
    end else begin
      mag_reg <= mag_next;
      neg_reg <= ph_hi[D];
      rf_reg  <= rf_next;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{prod_wide[N+PW-1:N], ph2[N-D-2:0]};

endmodule

// File: tb/tb_fm_modulator_pl.sv
// Directed bench for fm_modulator_pl (HOLD_MAX=16): reset, PWL sweep, modulation, underrun, config timing.
module tb_fm_modulator_pl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  audio = '0;
  logic        audio_valid = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [17:0] fc_inc = '0;
  logic [11:0] df_inc = '0;
  logic        cfg_pending, underrun;
  logic [4:0]  rf;

  int checks = 0;
  int failures = 0;

  int quad_exp[8]     = '{16, 31, 16, 1, 16, 31, 16, 1};
  int modp_exp[13]    = '{16, 31, 16, 1, 16, 31, 14, 1, 18, 31, 12, 1, 20};
  int modn_exp[11]    = '{16, 31, 16, 1, 16, 31, 18, 1, 14, 31, 20};
  int drop_exp[9]     = '{16, 24, 28, 31, 31, 31, 27, 22, 16};
  int cfg_rf_exp[5]   = '{1, 10, 31, 22, 1};
  int cfg_pend_exp[5] = '{1, 1, 1, 1, 0};

  fm_modulator_pl #(.A(8), .N(18), .D(5), .DF_W(12), .HOLD_MAX(16)) dut (
    .clk(clk), .rst(rst), .en(en), .audio(audio), .audio_valid(audio_valid),
    .cfg_valid(cfg_valid), .fc_inc(fc_inc), .df_inc(df_inc),
    .cfg_pending(cfg_pending), .underrun(underrun), .rf(rf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf !== 5'd16) begin failures++; $display("FAIL reset_rf got=%0d exp=16", rf); end
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL reset_underrun got=%0b exp=1", underrun); end
    checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%0b exp=0", cfg_pending); end
    rst = 1'b0;
    step();
    checks++; if (rf !== 5'd16) begin failures++; $display("FAIL post_reset_rf got=%0d exp=16", rf); end
    $display("test_reset rf=%0d underrun=%0b pending=%0b", rf, underrun, cfg_pending);
  endtask

  task automatic test_quadrant();
    en = 1'b0; cfg_valid = 1'b1; fc_inc = 18'd65536; df_inc = 12'd0;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_pending !== 1'b1) begin failures++; $display("FAIL quad_pend_write got=%0b exp=1", cfg_pending); end
    step();
    checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL quad_pend_apply got=%0b exp=0", cfg_pending); end
    en = 1'b1;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (rf !== 5'(quad_exp[i])) begin failures++; $display("FAIL quad_rf[%0d] got=%0d exp=%0d", i, rf, quad_exp[i]); end
      $display("quad k=%0d rf=%0d", i, rf);
      step();
    end
  endtask

  task automatic test_modulation();
    en = 1'b0; cfg_valid = 1'b1; fc_inc = 18'd65536; df_inc = 12'd1000;
    audio = 8'd127; audio_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    en = 1'b1;
    step(); step();
    for (int i = 0; i < 13; i++) begin
      checks++; if (rf !== 5'(modp_exp[i])) begin failures++; $display("FAIL modpos_rf[%0d] got=%0d exp=%0d", i, rf, modp_exp[i]); end
      $display("modpos k=%0d rf=%0d", i, rf);
      step();
    end
    en = 1'b0; audio = 8'h80;
    step();
    en = 1'b1;
    step(); step();
    for (int i = 0; i < 11; i++) begin
      checks++; if (rf !== 5'(modn_exp[i])) begin failures++; $display("FAIL modneg_rf[%0d] got=%0d exp=%0d", i, rf, modn_exp[i]); end
      $display("modneg k=%0d rf=%0d", i, rf);
      step();
    end
  endtask

  task automatic test_underrun();
    audio = 8'd127; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_after_valid got=%0b exp=0", underrun); end
    repeat (15) step();
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_at15 got=%0b exp=0", underrun); end
    step();
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_at16 got=%0b exp=1", underrun); end
    $display("underrun after 16 idle cycles = %0b", underrun);
    en = 1'b0;
    step();
    en = 1'b1;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (rf !== 5'(quad_exp[i])) begin failures++; $display("FAIL underrun_rf[%0d] got=%0d exp=%0d", i, rf, quad_exp[i]); end
      step();
    end
    audio = 8'd0; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%0b exp=0", underrun); end
    $display("underrun after new sample = %0b", underrun);
  endtask

  task automatic test_cfg_timing();
    en = 1'b0; cfg_valid = 1'b1; fc_inc = 18'd52428; df_inc = 12'd0;
    step();
    cfg_valid = 1'b0;
    step();
    checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL cfg_initial_pend got=%0b exp=0", cfg_pending); end
    en = 1'b1;
    step(); step();
    cfg_valid = 1'b1; fc_inc = 18'd65536;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_pending !== 1'b1) begin failures++; $display("FAIL cfg_pend_e3 got=%0b exp=1", cfg_pending); end
    step();
    checks++; if (cfg_pending !== 1'b1) begin failures++; $display("FAIL cfg_pend_e4 got=%0b exp=1", cfg_pending); end
    step();
    checks++; if (cfg_pending !== 1'b1) begin failures++; $display("FAIL cfg_pend_e5 got=%0b exp=1", cfg_pending); end
    step();
    checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL cfg_pend_wrap got=%0b exp=0", cfg_pending); end
    step(); step();
    checks++; if (rf !== 5'd31) begin failures++; $display("FAIL cfg_rf_e8 got=%0d exp=31", rf); end
    step();
    checks++; if (rf !== 5'd22) begin failures++; $display("FAIL cfg_rf_e9 got=%0d exp=22", rf); end
    cfg_valid = 1'b1; fc_inc = 18'd65536;
    for (int i = 0; i < 5; i++) begin
      step();
      cfg_valid = 1'b0;
      checks++; if (rf !== 5'(cfg_rf_exp[i])) begin failures++; $display("FAIL cfg_rf[%0d] got=%0d exp=%0d", i, rf, cfg_rf_exp[i]); end
      checks++; if (cfg_pending !== 1'(cfg_pend_exp[i])) begin failures++; $display("FAIL cfg_pend[%0d] got=%0b exp=%0d", i, cfg_pending, cfg_pend_exp[i]); end
      $display("cfg e%0d rf=%0d pending=%0b", 10 + i, rf, cfg_pending);
    end
  endtask

  task automatic test_en_drop();
    cfg_valid = 1'b1; fc_inc = 18'd16384; df_inc = 12'd0;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_pending !== 1'b1) begin failures++; $display("FAIL drop_pend_set got=%0b exp=1", cfg_pending); end
    en = 1'b0;
    step();
    checks++; if (rf !== 5'd16) begin failures++; $display("FAIL drop_rf got=%0d exp=16", rf); end
    checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL drop_pend_apply got=%0b exp=0", cfg_pending); end
    en = 1'b1;
    step(); step();
    for (int i = 0; i < 9; i++) begin
      checks++; if (rf !== 5'(drop_exp[i])) begin failures++; $display("FAIL drop_rf[%0d] got=%0d exp=%0d", i, rf, drop_exp[i]); end
      $display("drop k=%0d rf=%0d", i, rf);
      step();
    end
  endtask

  task automatic test_async_reset();
    cfg_valid = 1'b1; fc_inc = 18'd65536; df_inc = 12'd0;
    audio = 8'd5; audio_valid = 1'b1;
    step();
    cfg_valid = 1'b0; audio_valid = 1'b0;
    checks++; if (rf !== 5'd4) begin failures++; $display("FAIL pre_rst_rf got=%0d exp=4", rf); end
    checks++; if (cfg_pending !== 1'b1) begin failures++; $display("FAIL pre_rst_pend got=%0b exp=1", cfg_pending); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL pre_rst_underrun got=%0b exp=0", underrun); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rf !== 5'd16) begin failures++; $display("FAIL async_rst_rf got=%0d exp=16", rf); end
    checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL async_rst_pend got=%0b exp=0", cfg_pending); end
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL async_rst_underrun got=%0b exp=1", underrun); end
    $display("async reset rf=%0d pending=%0b underrun=%0b", rf, cfg_pending, underrun);
    step();
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b1; fc_inc = 18'd65536;
    step();
    cfg_valid = 1'b0;
    step();
    en = 1'b1;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (rf !== 5'(quad_exp[i])) begin failures++; $display("FAIL restart_rf[%0d] got=%0d exp=%0d", i, rf, quad_exp[i]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_quadrant();
    test_modulation();
    test_underrun();
    test_cfg_timing();
    test_en_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_modulator_pl.md
Name: fm_modulator_pl

Overview:
Parametrised, pipelined successor to the fixed-constant FM modulator. Carrier and deviation increments are set at runtime through a config interface and applied glitch-free on phase wrap. Audio enters through a valid strobe with hold-and-timeout underrun handling. Output is a D-bit offset-binary piecewise-linear sine that drives the DAC pins at the top level.

Parameters:
A, 8, audio sample width (signed 2's complement)
N, 18, phase accumulator width (N >= D+2)
D, 5, output/DAC width (D >= 4)
DF_W, 12, deviation increment width
HOLD_MAX, 4096, cycles without audio_valid before underrun (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  modulator enable
audio  in  A  signed audio sample
audio_valid  in  1  sample strobe, one cycle per sample
cfg_valid  in  1  load fc_inc/df_inc into shadow registers
fc_inc  in  N  carrier phase increment
df_inc  in  DF_W  full-scale deviation increment (unsigned)
cfg_pending  out  1  shadow config not yet applied
underrun  out  1  audio timeout active
rf  out  D  offset-binary RF sample

Behaviour:
- Reset (async, rst=1): phase=0, active/shadow fc=0, df=0, held sample=0, hold counter=0, cfg_pending=0, underrun=1, pipeline mag=0/neg=0, rf=2^(D-1).
- Audio: audio_valid=1 captures audio into held sample, clears hold counter, deasserts underrun next cycle. Otherwise counter increments, saturating at HOLD_MAX; on reaching HOLD_MAX: held sample<=0, underrun<=1.
- mod = (held_sample * signed({1'b0,df_act})) >>> (A-1), arithmetic shift (floor), sign-extended/truncated to N bits.
- Phase (stage 1): en=1: phase <= phase + fc_act + mod, mod 2^N. en=0: phase <= 0.
- Wrap = unsigned carry out of phase+fc_act+mod with mod >= 0, or borrow with mod < 0.
- Config: cfg_valid writes shadow, cfg_pending<=1. Shadow copied to active and cfg_pending<=0 on a wrap cycle, or on any cycle with en=0. A new value written on the apply cycle wins: it is stored in shadow and cfg_pending stays 1.
- Stage 2 (registered): q=phase[N-1:N-2], p=phase[N-3:0]; p'=~p if q odd else p; neg=q[1]; s=p'[N-3:N-4]; t=p'[N-3:N-1-D] (top D-1 bits).
  - mag = 2*t if s=0
  - mag = 2^(D-3)+t if s in {1,2}
  - mag = 2^(D-1)-1 if s=3
- Stage 3: rf <= 2^(D-1) + (neg ? -mag : mag), mod 2^D; en=0 forces rf <= 2^(D-1) and mag/neg <= 0.
- Latency: phase value at cycle t -> rf at t+2. Range 1..2^D-1.
- No handshake back-pressure: audio_valid every cycle is legal.

Optional Feature:
FM_PHASE_DITHER_EN: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset, advances every cycle with en=1). Its low K=min(N-D-1,16) bits, zero-extended, are added to the phase copy feeding stage 2 only; the accumulator itself is unaffected. Undefined macro: no LFSR, stage 2 uses phase directly.

Test Plan:
- Reset: assert rst mid-run -> rf=16, underrun=1, cfg_pending=0 immediately (async); phase restarts at 0 after release.
- Quadrant sweep: cfg fc_inc=65536, df_inc=0, en=0 then en=1 -> rf repeats 16,31,16,1, first 16 two cycles after en.
- Modulation: df_inc=1000, audio=127 valid -> per-cycle phase step fc+992; audio=-128 -> fc-1000.
- Underrun (HOLD_MAX=16): one audio_valid then none -> underrun rises after 16 cycles, step returns to fc; next audio_valid clears it.
- Config timing: en=1, fc=52428, write fc=65536 mid-cycle -> cfg_pending=1 until first wrap, new step from that cycle; write on wrap cycle -> pending stays 1.
- en drop: en=0 mid-run -> rf=16 within 2 cycles, phase=0, pending config applied.
